// File: rtl/alu_rr_scheduler_pkg.sv
// rtl/alu_rr_scheduler_pkg.sv - shared types and helpers for the round-robin ALU scheduler
// Purpose : ALU select encoding (matches the PD0 ALU), scheduler FSM states,
//           and the requester-ID width helper.
// Ports   : none (package).
package alu_sched_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      AND = 2'b10,
      OR  = 2'b11
   } alu_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } sched_state_e;

   // A single requester still needs a 1-bit ID field.
   function automatic int idw_of(input int num_req);
      return (num_req <= 1) ? 1 : $clog2(num_req);
   endfunction

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// rtl/alu_rr_scheduler_if.sv - request/ALU/response bundle for the round-robin ALU scheduler
// Purpose : groups the requester handshake, shared-ALU operand/result and
//           response channel signals.
// Ports   : req_valid/req_ready/req_sel/req_op1/req_op2 (requesters),
//           alu_sel/alu_op1/alu_op2/alu_res (shared ALU),
//           resp_valid/resp_ready/resp_id/resp_res (response), busy.
//           slave = scheduler side, master = environment side.
interface alu_rr_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 32
);
   localparam int IDW = alu_sched_pkg::idw_of(NUM_REQ);

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ*2-1:0]      req_sel;
   logic [NUM_REQ*DWIDTH-1:0] req_op1;
   logic [NUM_REQ*DWIDTH-1:0] req_op2;
   logic [1:0]                alu_sel;
   logic [DWIDTH-1:0]         alu_op1;
   logic [DWIDTH-1:0]         alu_op2;
   logic [DWIDTH-1:0]         alu_res;
   logic                      resp_valid;
   logic                      resp_ready;
   logic [IDW-1:0]            resp_id;
   logic [DWIDTH-1:0]         resp_res;
   logic                      busy;

   modport slave (
      input  req_valid, req_sel, req_op1, req_op2, alu_res, resp_ready,
      output req_ready, alu_sel, alu_op1, alu_op2, resp_valid, resp_id, resp_res, busy
   );

   modport master (
      output req_valid, req_sel, req_op1, req_op2, alu_res, resp_ready,
      input  req_ready, alu_sel, alu_op1, alu_op2, resp_valid, resp_id, resp_res, busy
   );

endinterface

// File: rtl/alu_rr_scheduler_rr_arbiter.sv
// rtl/alu_rr_scheduler_rr_arbiter.sv - combinational rotating-priority arbiter
// Purpose : picks the first asserted request starting at rr_ptr and wrapping.
// Ports   : req (request vector), rr_ptr (highest-priority index),
//           grant (one-hot or zero), any_grant, grant_idx (winner index).
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDW-1:0]     rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic               any_grant,
   output logic [IDW-1:0]     grant_idx
);

   int idx;

   always_comb begin
      idx       = 0;
      any_grant = 1'b0;
      grant_idx = '0;
      // Walk from lowest priority to highest so the last hit is the winner.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (req[idx]) begin
            any_grant = 1'b1;
            grant_idx = IDW'(idx);
         end
      end
      grant = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant[i] = any_grant && (int'(grant_idx) == i);
      end
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin sharing of one PD0 ALU between requesters
// Purpose : grants one request at a time, registers its operands onto the
//           shared ALU, captures the result and returns it tagged with the
//           requester ID on a valid/ready response channel.
// Ports   : clk, reset (sync, active-high), bus (alu_rr_scheduler_if.slave).
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   alu_rr_scheduler_if.slave bus
);

   localparam int IDW = idw_of(NUM_REQ);

   sched_state_e       state;
   logic [IDW-1:0]     rr_ptr;
   logic [IDW-1:0]     grant_id;
   alu_sel_e           alu_sel_q;
   logic [DWIDTH-1:0]  alu_op1_q;
   logic [DWIDTH-1:0]  alu_op2_q;
   logic               resp_valid_q;
   logic [IDW-1:0]     resp_id_q;
   logic [DWIDTH-1:0]  resp_res_q;

   logic [NUM_REQ-1:0] grant;
   logic               any_grant;
   logic [IDW-1:0]     grant_idx;
   logic               accept;
   logic [IDW-1:0]     next_ptr;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDW     (IDW)
   ) u_arb (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .any_grant (any_grant),
      .grant_idx (grant_idx)
   );

   // Ready is offered only in IDLE and never while reset is asserted.
   assign accept        = (state == IDLE) && any_grant && !reset;
   assign bus.req_ready = accept ? grant : '0;

   // Next start position is the requester after the one just served.
   assign next_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         rr_ptr       <= '0;
         grant_id     <= '0;
         alu_sel_q    <= ADD;
         alu_op1_q    <= '0;
         alu_op2_q    <= '0;
         resp_valid_q <= 1'b0;
         resp_id_q    <= '0;
         resp_res_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_grant) begin
                  alu_sel_q <= alu_sel_e'(bus.req_sel[grant_idx*2 +: 2]);
                  alu_op1_q <= bus.req_op1[grant_idx*DWIDTH +: DWIDTH];
                  alu_op2_q <= bus.req_op2[grant_idx*DWIDTH +: DWIDTH];
                  grant_id  <= grant_idx;
                  state     <= EXEC;
               end
            end
            EXEC: begin
               resp_res_q   <= bus.alu_res;
               resp_id_q    <= grant_id;
               resp_valid_q <= 1'b1;
               state        <= RESP;
            end
            RESP: begin
               if (bus.resp_ready) begin
                  resp_valid_q <= 1'b0;
                  rr_ptr       <= next_ptr;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.alu_sel    = alu_sel_q;
   assign bus.alu_op1    = alu_op1_q;
   assign bus.alu_op2    = alu_op2_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_id    = resp_id_q;
   assign bus.resp_res   = resp_res_q;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
   import alu_sched_pkg::*;

   localparam int N  = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   alu_rr_scheduler_if #(.NUM_REQ(N), .DWIDTH(DW)) bus ();

   alu_rr_scheduler #(.NUM_REQ(N), .DWIDTH(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int m_ptr = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] ref_alu(input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
      case (s)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a & b;
         default: return a | b;
      endcase
   endfunction

   // Stand-in for the shared combinational ALU.
   always_comb bus.alu_res = ref_alu(bus.alu_sel, bus.alu_op1, bus.alu_op2);

   // Round-robin reference: first valid requester at or after ptr, wrapping.
   function automatic int pick(input logic [N-1:0] v, input int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [1:0] s, input logic [DW-1:0] a, input logic [DW-1:0] b);
      bus.req_sel[2*i +: 2]   = s;
      bus.req_op1[DW*i +: DW] = a;
      bus.req_op2[DW*i +: DW] = b;
   endtask

   task automatic scramble();
      for (int i = 0; i < N; i++) begin
         set_req(i, 2'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom);
      end
      bus.req_valid = 4'($urandom_range(0, 15));
   endtask

   // One full transaction from the current cycle; returns the DUT's tag/result.
   task automatic run_txn(input int stall, input bit scr, output int id_obs, output logic [DW-1:0] res_obs, output int t_acc);
      int             id;
      logic [1:0]     s;
      logic [DW-1:0]  a, b, e_res;
      logic [N-1:0]   e_rdy;
      id      = pick(bus.req_valid, m_ptr);
      t_acc   = cyc;
      id_obs  = -1;
      res_obs = '0;
      if (id < 0) begin
         chk("idle_ready", bus.req_ready, 0);
         tick();
         return;
      end
      s = bus.req_sel[2*id +: 2];
      a = bus.req_op1[DW*id +: DW];
      b = bus.req_op2[DW*id +: DW];
      e_res = ref_alu(s, a, b);
      e_rdy = '0;
      e_rdy[id] = 1'b1;
      chk("grant", bus.req_ready, e_rdy);
      chk("busy_idle", bus.busy, 0);
      tick();
      if (scr) scramble();
      #1;
      chk("alu_sel", bus.alu_sel, s);
      chk("alu_op1", bus.alu_op1, a);
      chk("alu_op2", bus.alu_op2, b);
      chk("busy_exec", bus.busy, 1);
      chk("ready_exec", bus.req_ready, 0);
      chk("rv_exec", bus.resp_valid, 0);
      tick();
      chk("rv", bus.resp_valid, 1);
      chk("rid", bus.resp_id, id);
      chk("rres", bus.resp_res, e_res);
      chk("ready_resp", bus.req_ready, 0);
      id_obs  = int'(bus.resp_id);
      res_obs = bus.resp_res;
      for (int k = 0; k < stall; k++) begin
         tick();
         if (scr) scramble();
         #1;
         chk("stall_rv", bus.resp_valid, 1);
         chk("stall_rid", bus.resp_id, id);
         chk("stall_rres", bus.resp_res, e_res);
         chk("stall_ready", bus.req_ready, 0);
         chk("stall_alu_op1", bus.alu_op1, a);
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      chk("rv_done", bus.resp_valid, 0);
      chk("busy_done", bus.busy, 0);
      m_ptr = (id + 1) % N;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            id, t, t_prev;
      logic [DW-1:0] res;
      int            exp_ids [5] = '{0, 1, 2, 3, 0};

      reset          = 1'b1;
      bus.req_valid  = '1;
      bus.resp_ready = 1'b0;
      bus.req_sel    = '0;
      bus.req_op1    = '0;
      bus.req_op2    = '0;

      // Reset with every request asserted.
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_ready", bus.req_ready, 0);
         chk("rst_alu_sel", bus.alu_sel, 0);
         chk("rst_alu_op1", bus.alu_op1, 0);
         chk("rst_alu_op2", bus.alu_op2, 0);
         chk("rst_rv", bus.resp_valid, 0);
         chk("rst_rid", bus.resp_id, 0);
         chk("rst_rres", bus.resp_res, 0);
         chk("rst_busy", bus.busy, 0);
      end
      reset = 1'b0;
      set_req(0, 2'b00, 32'd5, 32'd7);
      set_req(1, 2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF);
      set_req(2, 2'b11, 32'h1000_0000, 32'h0000_0001);
      set_req(3, 2'b01, 32'd100, 32'd58);
      #1;
      chk("first_grant", bus.req_ready, 4'b0001);

      // All requesters held valid: 0,1,2,3,0 three cycles apart; first is ADD 5+7.
      t_prev = 0;
      for (int k = 0; k < 5; k++) begin
         run_txn(0, 1'b0, id, res, t);
         chk("rr_order", id, exp_ids[k]);
         if (k == 0) chk("add_res", res, 32'd12);
         if (k > 0) chk("rr_spacing", t - t_prev, 3);
         t_prev = t;
      end

      // req1 SUB 0-1 with a 5-cycle response stall.
      bus.req_valid = 4'b0010;
      set_req(1, 2'b01, 32'd0, 32'd1);
      #1;
      run_txn(5, 1'b0, id, res, t);
      chk("sub_id", id, 1);
      chk("sub_res", res, 32'hFFFF_FFFF);

      // rr_ptr is now 2: req3 wins over req1, then wrap back to req1.
      bus.req_valid = 4'b1010;
      #1;
      run_txn(0, 1'b0, id, res, t);
      chk("wrap_first", id, 3);
      run_txn(0, 1'b0, id, res, t);
      chk("wrap_second", id, 1);

      // Reset while in EXEC drops the op and restores the pointer.
      bus.req_valid = 4'b0100;
      #1;
      chk("pre_rst_grant", bus.req_ready, 4'b0100);
      tick();
      chk("pre_rst_busy", bus.busy, 1);
      reset = 1'b1;
      #1;
      chk("rst_exec_ready", bus.req_ready, 0);
      tick();
      reset = 1'b0;
      bus.req_valid = '0;
      #1;
      chk("rst_exec_rv", bus.resp_valid, 0);
      chk("rst_exec_busy", bus.busy, 0);
      chk("rst_exec_op1", bus.alu_op1, 0);
      chk("rst_exec_rres", bus.resp_res, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rst_exec_no_resp", bus.resp_valid, 0);
      end
      bus.req_valid = '1;
      #1;
      chk("rst_exec_ptr0", bus.req_ready, 4'b0001);
      m_ptr = 0;

      // Randomised traffic with stalls and requests that change while busy.
      for (int k = 0; k < 40; k++) begin
         scramble();
         #1;
         run_txn($urandom_range(0, 3), 1'b1, id, res, t);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational PD0 ALU (2-bit select, DWIDTH-bit operands) between NUM_REQ requesters.
- Requests are granted round-robin and the chosen operands are registered onto the ALU inputs.
- The ALU result is captured and returned on a valid/ready response channel tagged with the requester ID.
- Sits in the core between execution clients and the single ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (legal range 1..16).
- DWIDTH, 32, operand/result width.
- IDW, $clog2(NUM_REQ) with minimum 1, width of requester ID (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_sel  in  NUM_REQ*2  flattened ALU select; requester i at [2i+1:2i].
- req_op1  in  NUM_REQ*DWIDTH  flattened operand 1.
- req_op2  in  NUM_REQ*DWIDTH  flattened operand 2.
- alu_sel  out  2  registered select to shared ALU.
- alu_op1  out  DWIDTH  registered operand 1 to ALU.
- alu_op2  out  DWIDTH  registered operand 2 to ALU.
- alu_res  in  DWIDTH  combinational ALU result.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  IDW  requester index of response.
- resp_res  out  DWIDTH  captured result.
- busy  out  1  high whenever state != IDLE.

Behaviour:

Reset (synchronous, active-high):
- State=IDLE, rr_ptr=0, grant ID=0.
- alu_sel/op1/op2=0, resp_valid=0, resp_id=0, resp_res=0, busy=0.
- req_ready=0 in every cycle reset is high.

States: IDLE, EXEC, RESP.

IDLE:
- Winner = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- req_ready[winner]=1 combinationally, all other bits 0; the handshake completes this cycle.
- At the clock edge: latch winner's sel/op1/op2 into alu_*, latch the ID, go to EXEC.
- With no valid request, stay in IDLE with req_ready=0.

EXEC:
- alu_* are stable; req_ready=0.
- At the edge: resp_res<=alu_res, resp_id<=latched ID, resp_valid<=1, go to RESP.

RESP:
- resp_valid=1; resp_id and resp_res held stable; req_ready=0.
- On resp_valid&resp_ready: resp_valid<=0, rr_ptr<=(ID+1) mod NUM_REQ (NUM_REQ-1 wraps to 0), go to IDLE.

Timing:
- Accept at cycle T gives resp_valid at T+2.
- Peak throughput is 1 op per 3 cycles.

Operand and arithmetic rules:
- alu_* change only on acceptance and hold their value otherwise, including in IDLE.
- Result is passed through unmodified (modulo 2^DWIDTH).

Boundary conditions:
- A requester may drop req_valid before being granted; nothing is recorded for it.
- req_valid arriving while busy waits; no queueing beyond the request lines.
- resp_ready held low stalls indefinitely with no loss of data.
- Reset in EXEC or RESP drops the in-flight op: no response is produced and rr_ptr returns to 0.
- NUM_REQ=1: rr_ptr is always 0 and resp_id is always 0.

Decomposition:
- Package alu_sched_pkg:
  - alu_sel_e encoding, matching PD0 ALU: ADD=2'b00, SUB=2'b01, AND=2'b10, OR=2'b11.
  - sched_state_e {IDLE, EXEC, RESP}.
  - IDW helper function.
- Sub-module rr_arbiter:
  - Combinational, parameterised by NUM_REQ.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, any_grant, grant index.
  - Owns the rotating-priority search only.

Test Plan:
- Reset held 3 cycles with all req_valid=1: req_ready=0, and every output 0 throughout. First grant goes to req0 in the first cycle after reset falls.
- req0 ADD op1=5, op2=7 accepted at T, resp_ready=1: alu_sel=00, alu_op1=5 at T+1; resp_valid=1, resp_id=0, resp_res=12 at T+2; busy low at T+3.
- All four req_valid held high, resp_ready=1: grants 0,1,2,3,0 on successive IDLE cycles, each 3 cycles apart.
- resp_ready=0 for 5 cycles in RESP: resp_valid, resp_id, resp_res stable and req_ready=0. resp_ready=1 gives IDLE the next cycle.
- req1 SUB op1=0, op2=1 → resp_res=32'hFFFFFFFF. Then req1 and req3 valid with rr_ptr=2: req3 is granted first, rr_ptr wraps to 0, and req1 is granted next.
- Reset asserted during EXEC: no resp_valid ever appears for that op; state=IDLE, rr_ptr=0, outputs 0 next cycle.
